// File: rtl/log_frame_stats_if.sv
// Stream-in / statistics-out bundle for log_frame_stats.
// The master side drives the log-domain samples and consumes the published statistics.
interface log_frame_stats_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tdata_in;
  logic                  tvalid_in;
  logic                  clear;
  logic [DATA_WIDTH-1:0] stat_min;
  logic [DATA_WIDTH-1:0] stat_max;
  logic [DATA_WIDTH-1:0] stat_mean;
  logic [15:0]           frame_count;
  logic                  stat_valid;

  modport master (
    output tdata_in, tvalid_in, clear,
    input  stat_min, stat_max, stat_mean, frame_count, stat_valid
  );

  modport slave (
    input  tdata_in, tvalid_in, clear,
    output stat_min, stat_max, stat_mean, frame_count, stat_valid
  );
endinterface

// File: rtl/log_frame_stats.sv
// Per-frame min/max/mean collector for the log-domain pixel stream.
// Three stages: input register, accumulator FSM, publish register.
module log_frame_stats #(
  parameter int FRAME_PIXELS_LOG2 = 16,
  parameter int DATA_WIDTH        = 32
) (
  input logic              clk,
  input logic              rst_n,
  log_frame_stats_if.slave s
);

  localparam int CNT_W = FRAME_PIXELS_LOG2 + 1;
  localparam int SUM_W = DATA_WIDTH + FRAME_PIXELS_LOG2;
  localparam logic [CNT_W-1:0] FRAME_N = CNT_W'(1) << FRAME_PIXELS_LOG2;

  typedef enum logic {EMPTY, ACCUM} state_t;

  function automatic logic [DATA_WIDTH-1:0] min_u(input logic [DATA_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] max_u(input logic [DATA_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] mean_trunc(input logic [SUM_W-1:0] sum);
    return DATA_WIDTH'(sum >> FRAME_PIXELS_LOG2);
  endfunction

  logic [DATA_WIDTH-1:0] in_q;
  logic                  vld_q;
  logic                  clr_q;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [SUM_W-1:0]      sum_q, sum_d;
  logic [DATA_WIDTH-1:0] run_min_q, run_min_d;
  logic [DATA_WIDTH-1:0] run_max_q, run_max_d;
  logic                  done_q, done_d;

  logic [DATA_WIDTH-1:0] stat_min_q, stat_min_d;
  logic [DATA_WIDTH-1:0] stat_max_q, stat_max_d;
  logic [DATA_WIDTH-1:0] stat_mean_q, stat_mean_d;
  logic [15:0]           frame_count_q, frame_count_d;
  logic                  stat_valid_q, stat_valid_d;

  // Stage 0: input register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q  <= '0;
      vld_q <= 1'b0;
      clr_q <= 1'b0;
    end else begin
      in_q  <= s.tdata_in;
      vld_q <= s.tvalid_in;
      clr_q <= s.clear;
    end
  end

  // Stage 1: accumulator FSM
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    run_min_d = run_min_q;
    run_max_d = run_max_q;
    done_d    = 1'b0;
    if (vld_q) begin
      // A clear coinciding with a sample restarts the frame on that sample.
      if (clr_q || state_q == EMPTY) begin
        run_min_d = in_q;
        run_max_d = in_q;
        sum_d     = SUM_W'(in_q);
        cnt_d     = CNT_W'(1);
      end else begin
        run_min_d = min_u(run_min_q, in_q);
        run_max_d = max_u(run_max_q, in_q);
        sum_d     = sum_q + SUM_W'(in_q);
        cnt_d     = cnt_q + CNT_W'(1);
      end
      if (cnt_d == FRAME_N) begin
        done_d  = 1'b1;
        state_d = EMPTY;
        cnt_d   = '0;
      end else begin
        state_d = ACCUM;
      end
    end else if (clr_q) begin
      state_d = EMPTY;
      cnt_d   = '0;
      sum_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      cnt_q     <= '0;
      sum_q     <= '0;
      run_min_q <= '0;
      run_max_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      run_min_q <= run_min_d;
      run_max_q <= run_max_d;
      done_q    <= done_d;
    end
  end

  // Stage 2: publish; run_* still hold the completed frame while the next one loads
  always_comb begin
    stat_min_d    = stat_min_q;
    stat_max_d    = stat_max_q;
    stat_mean_d   = stat_mean_q;
    frame_count_d = frame_count_q;
    stat_valid_d  = done_q;
    if (done_q) begin
      stat_min_d    = run_min_q;
      stat_max_d    = run_max_q;
      stat_mean_d   = mean_trunc(sum_q);
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_min_q    <= '0;
      stat_max_q    <= '0;
      stat_mean_q   <= '0;
      frame_count_q <= '0;
      stat_valid_q  <= 1'b0;
    end else begin
      stat_min_q    <= stat_min_d;
      stat_max_q    <= stat_max_d;
      stat_mean_q   <= stat_mean_d;
      frame_count_q <= frame_count_d;
      stat_valid_q  <= stat_valid_d;
    end
  end

  assign s.stat_min    = stat_min_q;
  assign s.stat_max    = stat_max_q;
  assign s.stat_mean   = stat_mean_q;
  assign s.frame_count = frame_count_q;
  assign s.stat_valid  = stat_valid_q;

endmodule

// File: tb/tb_log_frame_stats.sv
// Directed bench for log_frame_stats: a 4-sample-frame instance and a 2-sample-frame instance.
module tb_log_frame_stats;

  logic clk;
  logic rst_n;
  int   checks;
  int   fails;
  int   nstrobe;

  log_frame_stats_if #(.DATA_WIDTH(32)) s  ();
  log_frame_stats_if #(.DATA_WIDTH(32)) s1 ();

  log_frame_stats #(.FRAME_PIXELS_LOG2(2), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .s(s)
  );

  log_frame_stats #(.FRAME_PIXELS_LOG2(1), .DATA_WIDTH(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .s(s1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (s.stat_valid) nstrobe++;

  task automatic drive(input logic [31:0] d, input logic v, input logic c);
    @(negedge clk);
    s.tdata_in  = d;
    s.tvalid_in = v;
    s.clear     = c;
  endtask

  // Edge k captures the last sample; report stat_valid at k+1..k+3 and stats at k+2.
  task automatic finish_frame(output logic [2:0] vpat, output logic [111:0] stats);
    @(posedge clk); #1;
    s.tvalid_in = 1'b0;
    s.clear     = 1'b0;
    @(posedge clk); #1;
    vpat[2] = s.stat_valid;
    @(posedge clk); #1;
    vpat[1] = s.stat_valid;
    stats   = {s.stat_min, s.stat_max, s.stat_mean, s.frame_count};
    @(posedge clk); #1;
    vpat[0] = s.stat_valid;
  endtask

  task automatic test_reset();
    logic [112:0] got;
    logic [112:0] got1;
    rst_n = 1'b0;
    s.tdata_in = '0; s.tvalid_in = 1'b0; s.clear = 1'b0;
    s1.tdata_in = '0; s1.tvalid_in = 1'b0; s1.clear = 1'b0;
    #12;
    got  = {s.stat_min, s.stat_max, s.stat_mean, s.frame_count, s.stat_valid};
    got1 = {s1.stat_min, s1.stat_max, s1.stat_mean, s1.frame_count, s1.stat_valid};
    checks++;
    if (got !== 113'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h want 0", got);
    end
    checks++;
    if (got1 !== 113'd0) begin
      fails++;
      $display("FAIL reset_outputs_f2: got %h want 0", got1);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_frame();
    logic [2:0]   vp;
    logic [111:0] st;
    int           n0;
    n0 = nstrobe;
    drive(32'h10, 1, 0);
    drive(32'h40, 1, 0);
    drive(32'h20, 1, 0);
    drive(32'h30, 1, 0);
    finish_frame(vp, st);
    checks++;
    if (vp !== 3'b010) begin
      fails++;
      $display("FAIL basic_strobe: got %b want 010", vp);
    end
    checks++;
    if (st !== {32'h10, 32'h40, 32'h28, 16'd1}) begin
      fails++;
      $display("FAIL basic_stats: got %h want %h", st, {32'h10, 32'h40, 32'h28, 16'd1});
    end
    checks++;
    if (nstrobe - n0 !== 1) begin
      fails++;
      $display("FAIL basic_strobe_count: got %0d want 1", nstrobe - n0);
    end
  endtask

  task automatic test_gaps_full_scale();
    logic [2:0]   vp;
    logic [111:0] st;
    for (int i = 0; i < 4; i++) begin
      drive(32'hFFFF_FFFF, 1, 0);
      if (i < 3) begin
        for (int g = 0; g < 3; g++) drive(32'h0, 0, 0);
      end
      if (i == 2) begin
        checks++;
        if (s.stat_min !== 32'h10) begin
          fails++;
          $display("FAIL gaps_hold_min: got %h want 00000010", s.stat_min);
        end
      end
    end
    finish_frame(vp, st);
    checks++;
    if (vp !== 3'b010) begin
      fails++;
      $display("FAIL gaps_strobe: got %b want 010", vp);
    end
    checks++;
    if (st !== {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'd2}) begin
      fails++;
      $display("FAIL gaps_stats: got %h want %h", st,
               {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'd2});
    end
  endtask

  task automatic test_clear_mid_frame();
    logic [2:0]   vp;
    logic [111:0] st;
    int           n0;
    n0 = nstrobe;
    drive(32'h05, 1, 0);
    drive(32'h06, 1, 0);
    drive(32'h100, 1, 1);
    drive(32'h200, 1, 0);
    drive(32'h300, 1, 0);
    drive(32'h300, 0, 0);
    drive(32'h300, 0, 0);
    checks++;
    if ({s.stat_max, s.frame_count} !== {32'hFFFF_FFFF, 16'd2} || nstrobe != n0) begin
      fails++;
      $display("FAIL clear_hold: got max %h count %0d strobes %0d want max ffffffff count 2 strobes 0",
               s.stat_max, s.frame_count, nstrobe - n0);
    end
    drive(32'h400, 1, 0);
    finish_frame(vp, st);
    checks++;
    if (vp !== 3'b010) begin
      fails++;
      $display("FAIL clear_strobe: got %b want 010", vp);
    end
    checks++;
    if (st !== {32'h100, 32'h400, 32'h280, 16'd3}) begin
      fails++;
      $display("FAIL clear_stats: got %h want %h", st, {32'h100, 32'h400, 32'h280, 16'd3});
    end
    checks++;
    if (nstrobe - n0 !== 1) begin
      fails++;
      $display("FAIL clear_strobe_count: got %0d want 1", nstrobe - n0);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [2:0]   vp;
    logic [111:0] st;
    logic [112:0] got;
    drive(32'h1, 1, 0);
    drive(32'h2, 1, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    s.tvalid_in = 1'b0;
    #1;
    got = {s.stat_min, s.stat_max, s.stat_mean, s.frame_count, s.stat_valid};
    checks++;
    if (got !== 113'd0) begin
      fails++;
      $display("FAIL reset_mid_outputs: got %h want 0", got);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(32'h1, 1, 0);
    drive(32'h2, 1, 0);
    drive(32'h3, 1, 0);
    drive(32'h4, 1, 0);
    finish_frame(vp, st);
    checks++;
    if (vp !== 3'b010) begin
      fails++;
      $display("FAIL reset_mid_strobe: got %b want 010", vp);
    end
    checks++;
    if (st !== {32'h1, 32'h4, 32'h2, 16'd1}) begin
      fails++;
      $display("FAIL reset_mid_stats: got %h want %h", st, {32'h1, 32'h4, 32'h2, 16'd1});
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0]  seq [4];
    logic [3:0]   vp;
    logic [111:0] st_a;
    logic [111:0] st_b;
    seq[0] = 32'd7; seq[1] = 32'd9; seq[2] = 32'd3; seq[3] = 32'd1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s1.tdata_in  = seq[i];
      s1.tvalid_in = 1'b1;
    end
    @(posedge clk); #1;
    s1.tvalid_in = 1'b0;
    vp[3] = s1.stat_valid;
    st_a  = {s1.stat_min, s1.stat_max, s1.stat_mean, s1.frame_count};
    @(posedge clk); #1;
    vp[2] = s1.stat_valid;
    @(posedge clk); #1;
    vp[1] = s1.stat_valid;
    st_b  = {s1.stat_min, s1.stat_max, s1.stat_mean, s1.frame_count};
    @(posedge clk); #1;
    vp[0] = s1.stat_valid;
    checks++;
    if (vp !== 4'b1010) begin
      fails++;
      $display("FAIL b2b_strobes: got %b want 1010", vp);
    end
    checks++;
    if (st_a !== {32'd7, 32'd9, 32'd8, 16'd1}) begin
      fails++;
      $display("FAIL b2b_frame1: got %h want %h", st_a, {32'd7, 32'd9, 32'd8, 16'd1});
    end
    checks++;
    if (st_b !== {32'd1, 32'd3, 32'd2, 16'd2}) begin
      fails++;
      $display("FAIL b2b_frame2: got %h want %h", st_b, {32'd1, 32'd3, 32'd2, 16'd2});
    end
  endtask

  task automatic test_count_wrap();
    logic [2:0]   vp;
    logic [111:0] st;
    @(negedge clk);
    force dut.frame_count_q = 16'hFFFF;
    #1;
    release dut.frame_count_q;
    for (int i = 0; i < 4; i++) drive(32'h8, 1, 0);
    finish_frame(vp, st);
    checks++;
    if (vp !== 3'b010) begin
      fails++;
      $display("FAIL wrap_strobe: got %b want 010", vp);
    end
    checks++;
    if (st !== {32'h8, 32'h8, 32'h8, 16'h0000}) begin
      fails++;
      $display("FAIL wrap_stats: got %h want %h", st, {32'h8, 32'h8, 32'h8, 16'h0000});
    end
  endtask

  initial begin
    checks  = 0;
    fails   = 0;
    nstrobe = 0;
    test_reset();
    test_basic_frame();
    test_gaps_full_scale();
    test_clear_mid_frame();
    test_reset_mid_frame();
    test_back_to_back();
    test_count_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
